// File: rtl/q_8_39_pkg.sv
// rtl/q_8_39_pkg.sv - shared constants and types for the q_8_39 sequential multiplier
//
// Purpose: operand width and controller state encoding shared by the
//          controller and the datapath top.
// Ports:   none (package).

package q_8_39_pkg;

  localparam int data_width = 4;

  // Only two codes are used; the other two decode back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01
  } state_t;

endpackage

// File: rtl/q_8_39_controller.sv
// rtl/q_8_39_controller.sv - load / add-decrement / done sequencer for the multiplier
//
// Purpose: two-state controller that accepts start in IDLE, then issues one
//          add_decr per remaining count until the datapath reports zero.
// Ports:
//   clk       in   system clock, rising edge
//   rst_b     in   synchronous active-high reset
//   start     in   begin a multiplication (sampled in IDLE only)
//   zero      in   datapath counter is zero
//   load_regs out  capture operands and clear the product
//   add_decr  out  add multiplicand to product and decrement counter
//   rdy       out  high while IDLE (Moore decode of state)

import q_8_39_pkg::*;

module q_8_39_controller (
  input  logic clk,
  input  logic rst_b,
  input  logic start,
  input  logic zero,
  output logic load_regs,
  output logic add_decr,
  output logic rdy
);

  state_t Q_out;
  state_t next_state;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      Q_out <= IDLE;
    end else begin
      Q_out <= next_state;
    end
  end

  always_comb begin
    next_state = IDLE;
    case (Q_out)
      IDLE:    next_state = start ? BUSY : IDLE;
      BUSY:    next_state = zero ? IDLE : BUSY;
      default: next_state = IDLE;
    endcase
  end

  // rdy depends on state only; the strobes also qualify on start/zero
  // so the datapath updates on the same edge as the transition.
  always_comb begin
    rdy       = 1'b0;
    load_regs = 1'b0;
    add_decr  = 1'b0;
    case (Q_out)
      IDLE: begin
        rdy       = 1'b1;
        load_regs = start;
      end
      BUSY: begin
        add_decr = ~zero;
      end
      default: begin
        rdy = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/q_8_39_multiplier.sv
// rtl/q_8_39_multiplier.sv - unsigned sequential multiplier by repeated addition
//
// Purpose: P = A * B computed as B additions of A into an accumulator.
//          rdy is low for B+1 cycles after start is accepted.
// Ports:
//   clk    in   system clock, rising edge
//   rst_b  in   synchronous active-high reset
//   start  in   begin a multiplication (sampled while rdy=1)
//   A      in   multiplicand, captured at load
//   B      in   multiplier, captured at load
//   rdy    out  idle / result valid
//   P      out  product register (accumulator)

import q_8_39_pkg::*;

module q_8_39_multiplier (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      start,
  input  logic [data_width-1:0]     A,
  input  logic [data_width-1:0]     B,
  output logic                      rdy,
  output logic [2*data_width-1:0]   P
);

  logic [data_width-1:0] ra;
  logic [data_width-1:0] cnt;
  logic                  load_regs;
  logic                  add_decr;
  logic                  zero;

  assign zero = (cnt == '0);

  q_8_39_controller controller_0 (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .zero      (zero),
    .load_regs (load_regs),
    .add_decr  (add_decr),
    .rdy       (rdy)
  );

  // add_decr is never issued with cnt==0, so cnt cannot wrap, and
  // (2^w-1)^2 fits in 2w bits so P cannot overflow.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      ra  <= '0;
      cnt <= '0;
      P   <= '0;
    end else if (load_regs) begin
      ra  <= A;
      cnt <= B;
      P   <= '0;
    end else if (add_decr) begin
      P   <= P + {{data_width{1'b0}}, ra};
      cnt <= cnt - data_width'(1);
    end
  end

endmodule

// File: tb/tb_q_8_39_multiplier.sv
// tb/tb_q_8_39_multiplier.sv - directed self-checking bench for q_8_39_multiplier

module tb_q_8_39_multiplier;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       rdy;
  logic [7:0] P;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  q_8_39_multiplier dut (
    .clk   (clk),
    .rst_b (rst_b),
    .start (start),
    .A     (A),
    .B     (B),
    .rdy   (rdy),
    .P     (P)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One start pulse; operands are scrambled after load to show they are ignored.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input string tag);
    int busy;
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    A = ~a;
    B = ~b;
    busy = 0;
    while (!rdy && busy < 40) begin
      busy++;
      tick();
    end
    check({tag, " busy"}, busy, int'(b) + 1);
    check({tag, " P"}, P, int'(a) * int'(b));
  endtask

  initial begin
    int busy;
    int ea;
    int eb;

    rst_b = 1'b1;
    start = 1'b0;
    A = 4'd0;
    B = 4'd0;
    tick();
    tick();
    check("reset rdy", rdy, 1);
    check("reset P", P, 0);
    check("reset state", dut.controller_0.Q_out, 2'b00);

    rst_b = 1'b0;
    tick();
    tick();
    tick();
    check("idle hold rdy", rdy, 1);
    check("idle hold state", dut.controller_0.Q_out, 2'b00);

    run_op(4'd5, 4'd3, "5x3");
    run_op(4'd9, 4'd0, "9x0");
    run_op(4'd0, 4'd7, "0x7");
    run_op(4'd15, 4'd15, "15x15");

    // Back-to-back with start held: each pair loads on the edge after rdy rises.
    ea = 0;
    eb = 0;
    A = 4'd0;
    B = 4'd0;
    start = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) begin
      busy = 0;
      while (!rdy && busy < 40) begin
        busy++;
        tick();
      end
      check($sformatf("exh %0dx%0d P", ea, eb), P, ea * eb);
      if (i < 255) begin
        ea = (i + 1) / 16;
        eb = (i + 1) % 16;
        A = 4'(ea);
        B = 4'(eb);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    tick();
    check("exh end rdy", rdy, 1);

    // Reset in the middle of 8x3: two additions done, P=16.
    A = 4'd8;
    B = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("midop add_decr", dut.add_decr, 1);
    check("midop zero", dut.zero, 0);
    tick();
    tick();
    check("midop partial P", P, 16);
    check("midop rdy low", rdy, 0);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    check("midrst rdy", rdy, 1);
    check("midrst P", P, 0);
    check("midrst state", dut.controller_0.Q_out, 2'b00);
    run_op(4'd8, 4'd3, "8x3 after rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
